// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 VGA timing constants and the
// pixel-fetch display state encoding.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP
                          + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP
                          + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    OFF,
    ARMED,
    SHOW
  } fetch_state_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with
// synchronous reset of every stage to RESET_VAL.
// Ports: i_clk, i_reset, i_d in; o_q = i_d delayed DEPTH.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sr[i] <= RESET_VAL;
      end
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: fetches a centred grayscale image
// from a sync-read framebuffer and drives aligned RGB.
// In: vgaclk, reset, hcnt/vcnt, hsync_in/vsync_in,
//   blank_b_in, display_en, mem_data.
// Out: mem_addr/mem_rd, hsync/vsync/blank_b,
//   red/green/blue, frame_start.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int X0      = 192,
  parameter int Y0      = 112,
  parameter int ADDR_W  = 16,
  parameter int PIX_W   = 8,
  parameter int MEM_LAT = 1,
  parameter logic [7:0] BORDER = 8'h00
) (
  input  logic              vgaclk,
  input  logic              reset,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_b_in,
  input  logic              display_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [PIX_W-1:0]  mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_b,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              frame_start
);

  localparam int LOG_W = $clog2(IMG_W);
  localparam int DEPTH = MEM_LAT + 1;

  if (X0 + IMG_W > H_ACTIVE) begin : g_chk_x
    $error("image exceeds active width");
  end
  if (Y0 + IMG_H > V_ACTIVE) begin : g_chk_y
    $error("image exceeds active height");
  end
  if ((IMG_W & (IMG_W - 1)) != 0) begin : g_chk_w
    $error("IMG_W must be a power of two");
  end
  if (ADDR_W < $clog2(IMG_W * IMG_H)) begin : g_chk_a
    $error("ADDR_W too small for image");
  end
  if (MEM_LAT < 1) begin : g_chk_l
    $error("MEM_LAT must be at least 1");
  end

  fetch_state_t      r_state;
  logic              r_frame_start;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_blank_b;
  logic [7:0]        r_gray;

  logic              w_origin;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_inside;
  logic [9:0]        w_hrel;
  logic [9:0]        w_vrel;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_gray;
  logic [3:0]        w_dl_q;
  logic              w_unused;

  assign w_origin = (hcnt == '0) && (vcnt == '0);

  assign w_in_x = (int'(hcnt) >= X0)
               && (int'(hcnt) < X0 + IMG_W);
  assign w_in_y = (int'(vcnt) >= Y0)
               && (int'(vcnt) < Y0 + IMG_H);

  assign w_inside = (r_state == SHOW) && blank_b_in
                 && w_in_x && w_in_y;

  // Relative counts wrap when outside the window,
  // but the address is only captured when inside.
  assign w_hrel = hcnt - 10'(X0);
  assign w_vrel = vcnt - 10'(Y0);
  assign w_addr = (ADDR_W'(w_vrel) << LOG_W)
                | ADDR_W'(w_hrel[LOG_W-1:0]);

  if (PIX_W >= 8) begin : g_wide
    assign w_gray = mem_data[PIX_W-1 -: 8];
  end else begin : g_narrow
    assign w_gray = {mem_data, {(8-PIX_W){1'b0}}};
  end

  assign w_unused = ^{w_hrel, mem_data};

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      r_state       <= OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      unique case (r_state)
        OFF: begin
          if (display_en) r_state <= ARMED;
        end
        ARMED: begin
          if (!display_en) begin
            r_state <= OFF;
          end else if (w_origin) begin
            r_state       <= SHOW;
            r_frame_start <= 1'b1;
          end
        end
        SHOW: begin
          // Leave only at a frame boundary.
          if (w_origin && !display_en) r_state <= OFF;
        end
        default: r_state <= OFF;
      endcase
    end
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_rd <= w_inside;
      if (w_inside) r_mem_addr <= w_addr;
    end
  end

  // Sync/blank/inside ride alongside the memory
  // access so they meet mem_data in the same cycle.
  vga_delay_line #(
    .WIDTH     (4),
    .DEPTH     (DEPTH),
    .RESET_VAL (4'b1100)
  ) u_dly (
    .i_clk   (vgaclk),
    .i_reset (reset),
    .i_d     ({hsync_in, vsync_in,
               blank_b_in, w_inside}),
    .o_q     (w_dl_q)
  );

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_b <= 1'b0;
      r_gray    <= 8'h00;
    end else begin
      r_hsync   <= w_dl_q[3];
      r_vsync   <= w_dl_q[2];
      r_blank_b <= w_dl_q[1];
      if (w_dl_q[0]) begin
        r_gray <= w_gray;
      end else if (w_dl_q[1]) begin
        r_gray <= BORDER;
      end else begin
        r_gray <= 8'h00;
      end
    end
  end

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_b     = r_blank_b;
  assign red         = r_gray;
  assign green       = r_gray;
  assign blue        = r_gray;
  assign frame_start = r_frame_start;

endmodule
